// File: rtl/multicycle_cpu_pkg.sv
// rtl/multicycle_cpu_pkg.sv - opcodes, funct codes, FSM states, ALU codes and datapath helpers
package multicycle_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {PC_INC, PC_BRANCH, PC_JUMP, PC_REG} pc_src_t;
    typedef enum logic [1:0] {B_REG, B_IMM, B_BR} alu_b_t;
    typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} rf_dst_t;
    typedef enum logic [1:0] {SRC_ALU, SRC_MDR, SRC_PC} rf_src_t;

    function automatic logic [31:0] sign_ext_16_to_32(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SUB: return a - b;
            ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - instruction sequencing FSM and per-state control decode
module multicycle_controller
    import multicycle_cpu_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic    clk,
    input  logic    rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic    zero,
    input  logic    mem_ready,
    output state_t  state,
    output logic    ir_we,
    output logic    pc_we,
    output logic    ab_we,
    output logic    aluout_we,
    output logic    mdr_we,
    output logic    rf_we,
    output pc_src_t pc_src,
    output logic    alu_src_a,
    output alu_b_t  alu_src_b,
    output alu_op_t alu_cntrl,
    output rf_dst_t rf_dst,
    output rf_src_t rf_src,
    output logic    mem_req,
    output logic    mem_we,
    output logic    halted,
    output logic    illegal
);

    logic is_r, is_jr, is_alu_r, known;
    alu_op_t r_op;

    assign is_r     = (opcode == OP_RTYPE);
    assign is_jr    = is_r && (funct == FN_JR);
    assign is_alu_r = is_r && (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    assign known    = is_alu_r || is_jr ||
                      (opcode inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL});
    assign halted   = (state == ST_HALT);

    always_comb begin
        case (funct)
            FN_SUB:  r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_SLT:  r_op = ALU_SLT;
            default: r_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_FETCH;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_FETCH:  if (mem_ready) state <= ST_DECODE;
                ST_DECODE: begin
                    if (opcode == HALT_OP) begin
                        state <= ST_HALT;
                    end else if (!known) begin
                        state   <= ST_HALT;
                        illegal <= 1'b1;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_alu_r || opcode == OP_ADDI)        state <= ST_WB;
                    else if (opcode == OP_LW || opcode == OP_SW) state <= ST_MEM;
                    else                                     state <= ST_FETCH;
                end
                ST_MEM:  if (mem_ready) state <= (opcode == OP_LW) ? ST_WB : ST_FETCH;
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_we = 1'b0; pc_we = 1'b0; ab_we = 1'b0; aluout_we = 1'b0;
        mdr_we = 1'b0; rf_we = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        pc_src = PC_INC; alu_src_a = 1'b0; alu_src_b = B_REG; alu_cntrl = ALU_ADD;
        rf_dst = DST_RT; rf_src = SRC_ALU;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            ST_DECODE: begin
                ab_we     = 1'b1;
                aluout_we = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = B_BR;
            end
            ST_EXEC: begin
                if (is_alu_r) begin
                    aluout_we = 1'b1;
                    alu_cntrl = r_op;
                end else if (is_jr) begin
                    pc_we  = 1'b1;
                    pc_src = PC_REG;
                end else if (opcode == OP_BEQ) begin
                    alu_cntrl = ALU_SUB;
                    pc_we     = zero;
                    pc_src    = PC_BRANCH;
                end else if (opcode == OP_J || opcode == OP_JAL) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JUMP;
                    rf_we  = (opcode == OP_JAL);
                    rf_dst = DST_RA;
                    rf_src = SRC_PC;
                end else begin
                    aluout_we = 1'b1;
                    alu_src_b = B_IMM;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_SW);
                mdr_we  = mem_ready && (opcode == OP_LW);
            end
            ST_WB: begin
                rf_we  = 1'b1;
                rf_dst = is_r ? DST_RD : DST_RT;
                rf_src = (opcode == OP_LW) ? SRC_MDR : SRC_ALU;
            end
            default: ;
        endcase
        // Reset kills any in-flight access at once, not at the next edge.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle MIPS-subset core with a single ready-handshaked memory port
module multicycle_cpu
    import multicycle_cpu_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_out
);

    state_t  state;
    logic    ir_we, pc_we, ab_we, aluout_we, mdr_we, rf_we, alu_src_a, zero;
    pc_src_t pc_src;
    alu_b_t  alu_src_b;
    alu_op_t alu_cntrl;
    rf_dst_t rf_dst;
    rf_src_t rf_src;

    logic [ADDR_W-1:0] pc, pc_next, addr_raw;
    logic [31:0] ir, a, b, aluout, mdr;
    logic [31:0] pc32, imm_ext, alu_a, alu_b, alu_y, jump_target, rf_wdata;
    logic [4:0]  rs, rt, rf_waddr;
    logic [31:0] rf [32];

    multicycle_controller #(.HALT_OP(HALT_OP)) u_ctrl (
        .clk(clk), .rst(rst), .opcode(ir[31:26]), .funct(ir[5:0]), .zero(zero),
        .mem_ready(mem_ready), .state(state), .ir_we(ir_we), .pc_we(pc_we),
        .ab_we(ab_we), .aluout_we(aluout_we), .mdr_we(mdr_we), .rf_we(rf_we),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_cntrl(alu_cntrl), .rf_dst(rf_dst), .rf_src(rf_src), .mem_req(mem_req),
        .mem_we(mem_we), .halted(halted), .illegal(illegal)
    );

    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign pc32        = 32'(pc);
    assign imm_ext     = sign_ext_16_to_32(ir[15:0]);
    assign alu_a       = alu_src_a ? pc32 : a;
    assign alu_y       = alu(alu_cntrl, alu_a, alu_b);
    assign zero        = (alu_y == 32'd0);
    assign jump_target = {pc32[31:28], ir[25:0], 2'b00};

    always_comb begin
        case (alu_src_b)
            B_IMM:   alu_b = imm_ext;
            B_BR:    alu_b = imm_ext << 2;
            default: alu_b = b;
        endcase
        case (pc_src)
            PC_BRANCH: pc_next = aluout[ADDR_W-1:0];
            PC_JUMP:   pc_next = jump_target[ADDR_W-1:0];
            PC_REG:    pc_next = a[ADDR_W-1:0];
            default:   pc_next = pc + ADDR_W'(4);
        endcase
        case (rf_dst)
            DST_RD:  rf_waddr = ir[15:11];
            DST_RA:  rf_waddr = 5'd31;
            default: rf_waddr = rt;
        endcase
        case (rf_src)
            SRC_MDR: rf_wdata = mdr;
            SRC_PC:  rf_wdata = pc32;
            default: rf_wdata = aluout;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            if (pc_we)     pc     <= pc_next;
            if (ir_we)     ir     <= mem_rdata;
            if (ab_we) begin
                a <= (rs == 5'd0) ? 32'd0 : rf[rs];
                b <= (rt == 5'd0) ? 32'd0 : rf[rt];
            end
            if (aluout_we) aluout <= alu_y;
            if (mdr_we)    mdr    <= mem_rdata;
        end
    end

    // Register file contents are deliberately left unreset; $0 is never written.
    always_ff @(posedge clk) begin
        if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
    end

    assign addr_raw  = (state == ST_MEM) ? aluout[ADDR_W-1:0] : pc;
    assign mem_addr  = addr_raw & ~ADDR_W'(3);
    assign mem_wdata = b;
    assign pc_out    = pc;

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - directed self-checking bench for multicycle_cpu
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom  [1024];
    logic [31:0] dmem [16];
    logic [31:0] log_addr [16];
    int          log_n;
    int          wait_n = 0;
    logic        block = 1'b0;
    int          cnt;
    int          stab_err = 0;
    logic        prev_wait;
    logic [31:0] prev_addr;
    int          cycles;
    int          req_bad;

    multicycle_cpu #(.ADDR_W(32), .RESET_PC(32'h40), .HALT_OP(6'b111111)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .illegal(illegal), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    always_comb mem_ready = mem_req && !block && (cnt >= wait_n);
    always_comb mem_rdata = (mem_addr < 32'h40) ? dmem[mem_addr[5:2]] : rom[mem_addr[11:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 32'd0;
            log_n     <= 0;
            cnt       <= 0;
            prev_wait <= 1'b0;
        end else begin
            cnt <= (!mem_req || mem_ready) ? 0 : cnt + 1;
            if (mem_req && prev_wait && mem_addr != prev_addr) stab_err <= stab_err + 1;
            prev_wait <= mem_req && !mem_ready;
            prev_addr <= mem_addr;
            if (mem_req && mem_ready && mem_we && mem_addr < 32'h40)
                dmem[mem_addr[5:2]] <= mem_wdata;
            if (mem_req && mem_ready && log_n < 16) begin
                log_addr[log_n] <= mem_addr;
                log_n <= log_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic run_to_halt(output int c);
        c = 0;
        while (!halted && c < 300) begin
            step();
            c++;
        end
    endtask

    task automatic load_arith();
        rom[16] = 32'h20010005;
        rom[17] = 32'h20020007;
        rom[18] = 32'h00221820;
        rom[19] = 32'hAC030010;
        rom[20] = 32'h8C040010;
        rom[21] = 32'hFC000000;
    endtask

    initial begin
        // Arithmetic/memory program with zero-wait memory
        load_arith();
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_pc", pc_out, 32'h40);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 32'h40);
        step();
        check("pc_after_fetch", pc_out, 32'h44);
        run_to_halt(cycles);
        check("cycles_zero_wait", cycles + 1, 32'd23);
        check("halted_t1", halted, 1'b1);
        check("illegal_t1", illegal, 1'b0);
        check("dmem_0x10", dmem[4], 32'd12);
        check("reg3", dut.rf[3], 32'd12);
        check("reg4", dut.rf[4], 32'd12);
        req_bad = 0;
        repeat (5) begin
            step();
            if (mem_req) req_bad++;
        end
        check("halt_no_req", req_bad, 0);

        // Same program with three wait states on every access
        wait_n = 3;
        do_reset();
        check("dmem_cleared", dmem[4], 32'd0);
        run_to_halt(cycles);
        check("cycles_wait3", cycles, 32'd47);
        check("dmem_0x10_wait", dmem[4], 32'd12);
        check("reg4_wait", dut.rf[4], 32'd12);
        check("illegal_wait", illegal, 1'b0);
        check("addr_stable", stab_err, 0);

        // jal / jr / beq self-loop
        wait_n = 0;
        rom[16] = 32'h0C000040;
        rom[17] = 32'h1021FFFF;
        rom[64] = 32'h03E00008;
        do_reset();
        repeat (3) step();
        check("jal_pc", pc_out, 32'h100);
        check("jal_ra", dut.rf[31], 32'h44);
        repeat (3) step();
        check("jr_pc", pc_out, 32'h44);
        repeat (9) step();
        check("fetch1", log_addr[1], 32'h100);
        check("fetch2", log_addr[2], 32'h44);
        check("fetch3", log_addr[3], 32'h44);
        check("fetch4", log_addr[4], 32'h44);
        check("beq_pc", pc_out, 32'h44);
        check("loop_not_halted", halted, 1'b0);

        // Unknown opcode
        rom[16] = 32'h54000000;
        do_reset();
        step();
        check("illegal_pre_decode", halted, 1'b0);
        step();
        check("illegal_halted", halted, 1'b1);
        check("illegal_flag", illegal, 1'b1);
        req_bad = 0;
        repeat (10) begin
            step();
            if (mem_req) req_bad++;
        end
        check("illegal_no_req", req_bad, 0);

        // Reset during a stalled data access
        rom[16] = 32'h8C050010;
        do_reset();
        repeat (2) step();
        block = 1'b1;
        step();
        check("mem_req_in_mem", mem_req, 1'b1);
        check("mem_addr_in_mem", mem_addr, 32'h10);
        check("mem_we_lw", mem_we, 1'b0);
        repeat (2) step();
        check("mem_addr_held", mem_addr, 32'h10);
        rst = 1'b1;
        #1;
        check("req_drop_on_rst", mem_req, 1'b0);
        check("pc_on_rst", pc_out, 32'h40);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        block = 1'b0;
        #1;
        check("restart_req", mem_req, 1'b1);
        check("restart_addr", mem_addr, 32'h40);
        step();
        check("restart_pc", pc_out, 32'h44);
        check("restart_log", log_addr[0], 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
